// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronize, debounce and edge-detect front-panel buttons
// Optional hold-combination reset request and fall suppression built when BTN_COMBO_RESET_EN is defined.
module button_conditioner #(
    parameter int              N_BTN           = 2,
    parameter int              SYNC_STAGES     = 2,
    parameter int              DEBOUNCE_CYCLES = 16,
    parameter bit              ACTIVE_LOW      = 1'b1,
    parameter logic [N_BTN-1:0] COMBO_MASK     = '1,
    parameter int              COMBO_HOLD      = 1024
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall,
    output logic             combo_reset
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_BTN-1:0] RELEASED = ACTIVE_LOW ? '1 : '0;

    logic [N_BTN-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]    db_cnt [N_BTN];
    logic [N_BTN-1:0] pressed;
    logic [N_BTN-1:0] toggle;
    logic [N_BTN-1:0] fall_block;

    // Chain preloads the released pin value so reset never looks like a press.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RELEASED;
            end
        end else begin
            sync_q[0] <= btn_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign pressed = sync_q[SYNC_STAGES-1] ^ {N_BTN{ACTIVE_LOW}};

    always_comb begin
        toggle = '0;
        for (int i = 0; i < N_BTN; i++) begin
            toggle[i] = (pressed[i] != btn_level[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
            btn_level <= '0;
            btn_rise  <= '0;
            btn_fall  <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if ((pressed[i] == btn_level[i]) || toggle[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
            btn_level <= btn_level ^ toggle;
            btn_rise  <= toggle & ~btn_level;
            btn_fall  <= toggle & btn_level & ~fall_block;
        end
    end

`ifdef BTN_COMBO_RESET_EN
    localparam int HW = $clog2(COMBO_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(COMBO_HOLD);

    logic [HW-1:0] hold_cnt;
    logic          supp_q;
    logic          all_held;

    assign all_held = &(btn_level | ~COMBO_MASK);

    // Suppression lasts until every masked button is released, so the release
    // that follows a combo reset is not seen as a fresh command.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_cnt <= '0;
            supp_q   <= 1'b0;
        end else begin
            if (!all_held) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
            if ((btn_level & COMBO_MASK) == '0) begin
                supp_q <= 1'b0;
            end else if (combo_reset) begin
                supp_q <= 1'b1;
            end
        end
    end

    assign combo_reset = (hold_cnt == HOLD_MAX);
    assign fall_block  = (combo_reset || supp_q) ? COMBO_MASK : '0;
`else
    logic unused_combo_cfg;

    assign unused_combo_cfg = (^COMBO_MASK) ^ (COMBO_HOLD != 0);
    assign combo_reset      = 1'b0;
    assign fall_block       = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
// Combo expectations follow BTN_COMBO_RESET_EN.
module tb_button_conditioner;

    logic       Clk;
    logic       Reset;
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_rise;
    logic [1:0] btn_fall;
    logic       combo_reset;

    int checks;
    int failures;
    bit combo_en;

    button_conditioner #(
        .N_BTN(2),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW(1'b1),
        .COMBO_MASK(2'b11),
        .COMBO_HOLD(8)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall),
        .combo_reset(combo_reset)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_reset();
        Reset   = 1'b1;
        btn_raw = 2'b11;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] exp_v;
        Reset   = 1'b1;
        btn_raw = 2'b00;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if ({btn_level, btn_rise, btn_fall, combo_reset} !== 7'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", c,
                         {btn_level, btn_rise, btn_fall, combo_reset}, 7'b0);
            end
        end
        Reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_v = {(e >= 6) ? 2'b11 : 2'b00, (e == 6) ? 2'b11 : 2'b00, 2'b00, 1'b0};
            checks++;
            if ({btn_level, btn_rise, btn_fall, combo_reset} !== exp_v) begin
                failures++;
                $display("FAIL reset_press edge=%0d got=%b want=%b", e,
                         {btn_level, btn_rise, btn_fall, combo_reset}, exp_v);
            end
        end
        // Reset while both buttons are held: outputs clear, then a fresh press.
        Reset = 1'b1;
        tick();
        checks++;
        if ({btn_level, btn_rise, btn_fall, combo_reset} !== 7'b0) begin
            failures++;
            $display("FAIL reset_mid got=%b want=%b",
                     {btn_level, btn_rise, btn_fall, combo_reset}, 7'b0);
        end
        tick();
        Reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_v = {(e >= 6) ? 2'b11 : 2'b00, (e == 6) ? 2'b11 : 2'b00, 2'b00, 1'b0};
            checks++;
            if ({btn_level, btn_rise, btn_fall, combo_reset} !== exp_v) begin
                failures++;
                $display("FAIL reset_redetect edge=%0d got=%b want=%b", e,
                         {btn_level, btn_rise, btn_fall, combo_reset}, exp_v);
            end
        end
        idle_reset();
    endtask

    task automatic test_press();
        logic [6:0] exp_v;
        btn_raw = 2'b10;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_v = {(e >= 6) ? 2'b01 : 2'b00, (e == 6) ? 2'b01 : 2'b00, 2'b00, 1'b0};
            checks++;
            if ({btn_level, btn_rise, btn_fall, combo_reset} !== exp_v) begin
                failures++;
                $display("FAIL press edge=%0d got=%b want=%b", e,
                         {btn_level, btn_rise, btn_fall, combo_reset}, exp_v);
            end
        end
        btn_raw = 2'b11;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_v = {(e >= 6) ? 2'b00 : 2'b01, 2'b00, (e == 6) ? 2'b01 : 2'b00, 1'b0};
            checks++;
            if ({btn_level, btn_rise, btn_fall, combo_reset} !== exp_v) begin
                failures++;
                $display("FAIL release edge=%0d got=%b want=%b", e,
                         {btn_level, btn_rise, btn_fall, combo_reset}, exp_v);
            end
        end
    endtask

    task automatic test_reject();
        for (int e = 1; e <= 12; e++) begin
            btn_raw = (e <= 3) ? 2'b01 : 2'b11;
            tick();
            checks++;
            if ({btn_level, btn_rise, btn_fall, combo_reset} !== 7'b0) begin
                failures++;
                $display("FAIL reject edge=%0d got=%b want=%b", e,
                         {btn_level, btn_rise, btn_fall, combo_reset}, 7'b0);
            end
        end
    endtask

    task automatic test_bounce();
        logic [6:0] exp_v;
        logic [5:0] pat;
        pat = 6'b000010;
        for (int e = 1; e <= 10; e++) begin
            btn_raw = {1'b1, (e <= 6) ? pat[e-1] : 1'b0};
            tick();
            exp_v = {(e >= 8) ? 2'b01 : 2'b00, (e == 8) ? 2'b01 : 2'b00, 2'b00, 1'b0};
            checks++;
            if ({btn_level, btn_rise, btn_fall, combo_reset} !== exp_v) begin
                failures++;
                $display("FAIL bounce edge=%0d got=%b want=%b", e,
                         {btn_level, btn_rise, btn_fall, combo_reset}, exp_v);
            end
        end
        btn_raw = 2'b11;
        for (int e = 1; e <= 8; e++) begin
            tick();
        end
        checks++;
        if ({btn_level, btn_rise, btn_fall, combo_reset} !== 7'b0) begin
            failures++;
            $display("FAIL bounce_release got=%b want=%b",
                     {btn_level, btn_rise, btn_fall, combo_reset}, 7'b0);
        end
    endtask

    task automatic test_combo();
        logic [6:0] exp_v;
        btn_raw = 2'b00;
        for (int e = 1; e <= 16; e++) begin
            tick();
            exp_v = {(e >= 6) ? 2'b11 : 2'b00, (e == 6) ? 2'b11 : 2'b00, 2'b00,
                     combo_en && (e >= 14)};
            checks++;
            if ({btn_level, btn_rise, btn_fall, combo_reset} !== exp_v) begin
                failures++;
                $display("FAIL combo_hold edge=%0d got=%b want=%b", e,
                         {btn_level, btn_rise, btn_fall, combo_reset}, exp_v);
            end
        end
        btn_raw = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_v = {(e >= 6) ? 2'b10 : 2'b11, 2'b00,
                     (!combo_en && e == 6) ? 2'b01 : 2'b00, combo_en && (e < 7)};
            checks++;
            if ({btn_level, btn_rise, btn_fall, combo_reset} !== exp_v) begin
                failures++;
                $display("FAIL combo_rel0 edge=%0d got=%b want=%b", e,
                         {btn_level, btn_rise, btn_fall, combo_reset}, exp_v);
            end
        end
        btn_raw = 2'b11;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_v = {(e >= 6) ? 2'b00 : 2'b10, 2'b00,
                     (!combo_en && e == 6) ? 2'b10 : 2'b00, 1'b0};
            checks++;
            if ({btn_level, btn_rise, btn_fall, combo_reset} !== exp_v) begin
                failures++;
                $display("FAIL combo_rel1 edge=%0d got=%b want=%b", e,
                         {btn_level, btn_rise, btn_fall, combo_reset}, exp_v);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
`ifdef BTN_COMBO_RESET_EN
        combo_en = 1'b1;
`else
        combo_en = 1'b0;
`endif
        Reset   = 1'b1;
        btn_raw = 2'b11;
        test_reset();
        test_press();
        test_reject();
        test_bounce();
        test_combo();
        test_press();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
